// File: rtl/elastic_memory_responder_pkg.sv
// Shared constants and state encoding for the elastic memory responder.
// MEM_LOAD_CYCLE is the load latency the ALU also uses to time loads.
package elastic_memory_responder_pkg;

    localparam int unsigned MEM_DATA_WIDTH    = 32;
    localparam int unsigned MEM_ADDRESS_WIDTH = 8;
    localparam int unsigned MEM_LOAD_CYCLE    = 2;

    typedef enum logic [1:0] {
        MEM_IDLE    = 2'd0,
        MEM_ACCESS  = 2'd1,
        MEM_RESPOND = 2'd2
    } mem_state_e;

endpackage

// File: rtl/elastic_memory_responder_array.sv
// Word-addressed storage: synchronous write, combinational read that the
// responder samples at request acceptance. Contents are never reset.
module elastic_mem_array #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/elastic_memory_responder.sv
// Memory-side responder on SELF valid/stop channels with fixed read latency.
// Optional macro ELASTIC_MEM_PIPELINE_EN overlaps a response transfer with the next request.
module elastic_memory_responder
    import elastic_memory_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = MEM_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = MEM_ADDRESS_WIDTH,
    parameter int unsigned LOAD_CYCLE    = MEM_LOAD_CYCLE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_stop,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0]    req_write_data,
    output logic                     resp_valid,
    input  logic                     resp_stop,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic                     idle
);

    localparam int unsigned CW = $clog2(LOAD_CYCLE + 1);

    if (LOAD_CYCLE < 1) begin : g_bad_load_cycle
        $error("elastic_memory_responder: LOAD_CYCLE must be >= 1");
    end

    mem_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  req_fire, resp_fire, wr_fire, rd_fire;

    assign req_fire  = req_valid & ~req_stop;
    assign resp_fire = resp_valid & ~resp_stop;
    assign wr_fire   = req_fire & req_write;
    assign rd_fire   = req_fire & ~req_write;

    elastic_mem_array #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_array (
        .clk  (clk),
        .we   (wr_fire),
        .waddr(req_address),
        .wdata(req_write_data),
        .raddr(req_address),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            MEM_IDLE: begin
                if (rd_fire) begin
                    data_d  = mem_rdata;
                    state_d = (LOAD_CYCLE == 1) ? MEM_RESPOND : MEM_ACCESS;
                    cnt_d   = CW'(LOAD_CYCLE - 1);
                end
            end
            MEM_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
                if (cnt_q == CW'(1)) begin
                    state_d = MEM_RESPOND;
                end
            end
            MEM_RESPOND: begin
                if (resp_fire) begin
                    state_d = MEM_IDLE;
`ifdef ELASTIC_MEM_PIPELINE_EN
                    // req_stop follows resp_stop here, so any accepted request coincides with resp_fire
                    if (rd_fire) begin
                        data_d  = mem_rdata;
                        state_d = (LOAD_CYCLE == 1) ? MEM_RESPOND : MEM_ACCESS;
                        cnt_d   = CW'(LOAD_CYCLE - 1);
                    end
`endif
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_comb begin
        resp_valid = (state_q == MEM_RESPOND);
        idle       = (state_q == MEM_IDLE);
`ifdef ELASTIC_MEM_PIPELINE_EN
        req_stop   = (state_q == MEM_RESPOND) ? resp_stop : (state_q != MEM_IDLE);
`else
        req_stop   = (state_q != MEM_IDLE);
`endif
    end

    assign resp_data = data_q;

endmodule

// File: tb/tb_elastic_memory_responder.sv
// Self-checking bench: three responders with LOAD_CYCLE 1, 2, 3 (instance k uses k+1).
// Reads push expected data and acceptance cycle; a negedge monitor pops and checks responses.
module tb_elastic_memory_responder;

`ifdef ELASTIC_MEM_PIPELINE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        int          acc;
    } exp_t;

    typedef struct {
        int          k;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        bit          chk_stall;
    } vec_t;

    logic        clk;
    logic        reset          [3];
    logic        req_valid      [3];
    logic        req_stop       [3];
    logic        req_write      [3];
    logic [7:0]  req_address    [3];
    logic [31:0] req_write_data [3];
    logic        resp_valid     [3];
    logic        resp_stop      [3];
    logic [31:0] resp_data      [3];
    logic        idle           [3];

    int   cyc = 0;
    int   ncmp = 0;
    int   nfail = 0;
    bit   seen [3];
    exp_t q0[$], q1[$], q2[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        elastic_memory_responder #(
            .DATA_WIDTH   (32),
            .ADDRESS_WIDTH(8),
            .LOAD_CYCLE   (g + 1)
        ) u_dut (
            .clk           (clk),
            .reset         (reset[g]),
            .req_valid     (req_valid[g]),
            .req_stop      (req_stop[g]),
            .req_write     (req_write[g]),
            .req_address   (req_address[g]),
            .req_write_data(req_write_data[g]),
            .resp_valid    (resp_valid[g]),
            .resp_stop     (resp_stop[g]),
            .resp_data     (resp_data[g]),
            .idle          (idle[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qfront(input int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpush(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic qpop(input int k);
        case (k)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    // Response monitor: latency checked on first valid cycle, data on transfer.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset[k]) begin
                seen[k] = 1'b0;
            end else if (resp_valid[k]) begin
                if (qsize(k) == 0) begin
                    check($sformatf("unexpected_resp%0d", k), 32'(resp_valid[k]), 32'd0);
                end else begin
                    exp_t e;
                    e = qfront(k);
                    if (!seen[k]) begin
                        check($sformatf("latency%0d", k), 32'((cyc + 1) - e.acc), 32'(k + 1));
                        seen[k] = 1'b1;
                    end
                    if (!resp_stop[k]) begin
                        check($sformatf("resp_data%0d", k), resp_data[k], e.data);
                        qpop(k);
                        seen[k] = 1'b0;
                    end
                end
            end
        end
    end

    // Presents one request and holds it until accepted; called just after a posedge.
    task automatic op(input int k, input bit wr, input logic [7:0] a, input logic [31:0] d,
                      input bit push, output int acc, output int stalls);
        exp_t e;
        acc    = -1;
        stalls = 0;
        req_write[k]      = wr;
        req_address[k]    = a;
        req_write_data[k] = d;
        req_valid[k]      = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!req_stop[k]) begin
                acc = cyc + 1;
                if (!wr && push) begin
                    e.data = d;
                    e.acc  = acc;
                    qpush(k, e);
                end
                @(posedge clk);
                #1;
                break;
            end
            stalls++;
        end
        req_valid[k] = 1'b0;
        if (acc < 0) check($sformatf("accept_timeout%0d", k), 32'd0, 32'd1);
    endtask

    vec_t vecs [13];

    initial begin
        int acc, stalls, a_prev;
        int accs [4];

        vecs[0]  = '{1, 1'b1, 8'd3,   32'h0000_00A5, 1'b0};
        vecs[1]  = '{1, 1'b1, 8'd4,   32'h0000_005A, 1'b1};
        vecs[2]  = '{1, 1'b0, 8'd3,   32'h0000_00A5, 1'b0};
        vecs[3]  = '{1, 1'b0, 8'd4,   32'h0000_005A, 1'b0};
        vecs[4]  = '{1, 1'b1, 8'd0,   32'hFFFF_FFFF, 1'b0};
        vecs[5]  = '{1, 1'b1, 8'd255, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1, 1'b1, 8'd7,   32'h0000_0011, 1'b1};
        vecs[7]  = '{1, 1'b0, 8'd255, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1, 1'b0, 8'd0,   32'hFFFF_FFFF, 1'b0};
        vecs[9]  = '{0, 1'b1, 8'd0,   32'h0000_1234, 1'b0};
        vecs[10] = '{0, 1'b0, 8'd0,   32'h0000_1234, 1'b0};
        vecs[11] = '{2, 1'b1, 8'd5,   32'hC0FF_EE05, 1'b0};
        vecs[12] = '{2, 1'b0, 8'd5,   32'hC0FF_EE05, 1'b0};

        for (int k = 0; k < 3; k++) begin
            reset[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0;
            req_address[k] = '0; req_write_data[k] = '0; resp_stop[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_resp_valid%0d", k), 32'(resp_valid[k]), 32'd0);
            check($sformatf("rst_req_stop%0d", k),   32'(req_stop[k]),   32'd0);
            check($sformatf("rst_idle%0d", k),       32'(idle[k]),       32'd1);
            check($sformatf("rst_resp_data%0d", k),  resp_data[k],       32'd0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) reset[k] = 1'b0;

        for (int i = 0; i < 13; i++) begin
            op(vecs[i].k, vecs[i].wr, vecs[i].addr, vecs[i].data, 1'b1, acc, stalls);
            if (vecs[i].chk_stall) check($sformatf("b2b_write_stall[%0d]", i), 32'(stalls), 32'd0);
        end

        // Reset during ACCESS on the LOAD_CYCLE=3 instance drops the pending read.
        op(2, 1'b0, 8'd5, 32'h0, 1'b0, acc, stalls);
        @(negedge clk);
        check("mid_access_idle", 32'(idle[2]), 32'd0);
        @(posedge clk); #1;
        reset[2] = 1'b1;
        #1;
        check("mid_rst_resp_valid", 32'(resp_valid[2]), 32'd0);
        check("mid_rst_idle",       32'(idle[2]),       32'd1);
        check("mid_rst_req_stop",   32'(req_stop[2]),   32'd0);
        check("mid_rst_resp_data",  resp_data[2],       32'd0);
        @(posedge clk); #1;
        reset[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_resp_after_rst", 32'(resp_valid[2]), 32'd0);
        end
        @(posedge clk); #1;
        op(2, 1'b0, 8'd5, 32'hC0FF_EE05, 1'b1, acc, stalls);

        // Response backpressure holds data and stalls requests.
        resp_stop[1] = 1'b1;
        op(1, 1'b0, 8'd3, 32'h0000_00A5, 1'b1, acc, stalls);
        for (int i = 0; i < 10 && !resp_valid[1]; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_resp_valid", 32'(resp_valid[1]), 32'd1);
            check("bp_resp_data",  resp_data[1],       32'h0000_00A5);
            check("bp_req_stop",   32'(req_stop[1]),   32'd1);
        end
        @(posedge clk); #1;
        resp_stop[1] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_idle_after", 32'(idle[1]), 32'd1);
        @(posedge clk); #1;

        // A store issued during ACCESS waits; the read keeps the old value.
        op(1, 1'b0, 8'd7, 32'h0000_0011, 1'b1, acc, stalls);
        op(1, 1'b1, 8'd7, 32'h0000_0022, 1'b1, acc, stalls);
        check("stalled_write_cycles", 32'(stalls), PIPE ? 32'd1 : 32'd2);
        op(1, 1'b0, 8'd7, 32'h0000_0022, 1'b1, acc, stalls);

        // Continuous reads: acceptance spacing.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                op(k, 1'b0, (k == 2) ? 8'd5 : 8'd0,
                   (k == 0) ? 32'h0000_1234 : (k == 1) ? 32'hFFFF_FFFF : 32'hC0FF_EE05,
                   1'b1, accs[i], stalls);
            end
            for (int i = 1; i < 4; i++) begin
                check($sformatf("spacing%0d[%0d]", k, i), 32'(accs[i] - accs[i-1]),
                      PIPE ? 32'(k + 1) : 32'(k + 2));
            end
        end

        a_prev = 0;
        for (int i = 0; i < 50; i++) begin
            if (qsize(0) + qsize(1) + qsize(2) == 0) break;
            @(negedge clk);
            a_prev++;
        end
        check("scoreboard_drained", 32'(qsize(0) + qsize(1) + qsize(2)), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
